// File: rtl/fbank_mel_accum_if.sv
// Stream bundle for the mel accumulator: spectrum bins in, band energies out.
// slave  : the accumulator's view (consumes bins, produces bands)
// master : the environment's view (produces bins, consumes bands)
interface fbank_mel_accum_if #(
  parameter int POW_W = 32,
  parameter int ACC_W = 32
);
  logic             s_valid;
  logic             s_ready;
  logic [POW_W-1:0] s_data;
  logic             s_last;
  logic             m_valid;
  logic             m_ready;
  logic [ACC_W-1:0] m_data;
  logic [6:0]       m_band;
  logic             m_last;

  modport slave (
    input  s_valid, s_data, s_last, m_ready,
    output s_ready, m_valid, m_data, m_band, m_last
  );

  modport master (
    output s_valid, s_data, s_last, m_ready,
    input  s_ready, m_valid, m_data, m_band, m_last
  );
endinterface

// File: rtl/fbank_mel_accum.sv
// Mel filterbank accumulator. Each power bin is split across bands k and k+1
// using the LUT weight, summed per band with saturation, and streamed out at
// frame end. Optional macro FBANK_LOG2_EN switches the output to a 6.4 log2
// encoding and adds one register stage before the first band.

// One band accumulator: cleared in CLR, adds at most one weighted term per cycle.
module fbank_mel_cell #(
  parameter int POW_W = 32,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             tb_rst,
  input  logic             clr,
  input  logic             sel_lo,
  input  logic             sel_hi,
  input  logic [POW_W-1:0] p_lo,
  input  logic [POW_W-1:0] p_hi,
  output logic [ACC_W-1:0] acc,
  output logic             sat_hit
);
  localparam int SW = ((ACC_W > POW_W) ? ACC_W : POW_W) + 1;

  logic [POW_W-1:0] add;
  logic [SW-1:0]    sum;

  // A band is either k or k+1 for a given bin, never both, so one adder suffices
  always_comb begin
    add     = sel_lo ? p_lo : (sel_hi ? p_hi : '0);
    sum     = SW'(acc) + SW'(add);
    sat_hit = (sel_lo || sel_hi) && (sum > SW'({ACC_W{1'b1}}));
  end

  // Accumulator register, clamps at all-ones
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)                acc <= '0;
    else if (clr)              acc <= '0;
    else if (sel_lo || sel_hi) acc <= sat_hit ? '1 : ACC_W'(sum);
  end
endmodule

module fbank_mel_accum #(
  parameter int NUM_BINS  = 257,
  parameter int NUM_BANDS = 40,
  parameter int POW_W     = 32,
  parameter int ACC_W     = 32
) (
  input  logic                clk,
  input  logic                tb_rst,
  fbank_mel_accum_if.slave    bus,
  output logic [9:0]          lut_addr,
  input  logic [16:0]         lut_rd_data,
  output logic                frame_err,
  output logic                sat
);
  localparam int BI_W = $clog2(NUM_BANDS);

  typedef enum logic [2:0] {CLR, ACC, DRAIN, PREP, OUT} state_t;

  state_t                              state, state_nxt;
  logic [10:0]                         bin_cnt;
  logic [6:0]                          band_cnt;
  logic                                band_end;
  logic                                in_hs, out_hs;
  logic                                s1_vld;
  logic [POW_W-1:0]                    pow_q;
  logic [6:0]                          k;
  logic [9:0]                          w;
  logic [7:0]                          k_inc;
  logic [10:0]                         w_hi;
  logic [POW_W-1:0]                    p_lo, p_hi;
  logic [NUM_BANDS-1:0][ACC_W-1:0]     acc;
  logic [NUM_BANDS-1:0]                sat_hit;

  assign band_end      = (band_cnt == 7'(NUM_BANDS - 1));
  assign bus.s_ready   = (state == ACC);
  assign bus.m_valid   = (state == OUT);
  assign bus.m_band    = (state == OUT) ? band_cnt : '0;
  assign bus.m_last    = (state == OUT) && band_end;
  assign in_hs         = bus.s_valid && (state == ACC);
  assign out_hs        = bus.m_ready && (state == OUT);
  // Past the last real bin the address parks on the final entry
  assign lut_addr      = (bin_cnt >= 11'(NUM_BINS)) ? 10'(NUM_BINS - 1) : bin_cnt[9:0];

  // Stage 1 operands: LUT word arrives the cycle after the address, beside pow_q
  assign k     = lut_rd_data[16:10];
  assign w     = lut_rd_data[9:0];
  assign k_inc = {1'b0, k} + 8'd1;
  assign w_hi  = 11'd1024 - {1'b0, w};
  assign p_lo  = POW_W'(({10'd0, pow_q} * {{POW_W{1'b0}}, w}) >> 10);
  assign p_hi  = POW_W'(({10'd0, pow_q} * {{(POW_W-1){1'b0}}, w_hi}) >> 10);

  // State register
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) state <= CLR;
    else        state <= state_nxt;
  end

  // Next-state: CLR sweep, accept bins, drain stage 1, stream bands
  always_comb begin
    state_nxt = state;
    case (state)
      CLR:   if (band_end) state_nxt = ACC;
      ACC:   if (in_hs && bus.s_last) state_nxt = DRAIN;
`ifdef FBANK_LOG2_EN
      DRAIN: state_nxt = PREP;
`else
      DRAIN: state_nxt = OUT;
`endif
      PREP:  state_nxt = OUT;
      OUT:   if (out_hs && band_end) state_nxt = CLR;
      default: state_nxt = CLR;
    endcase
  end

  // band_cnt walks the CLR sweep and the OUT stream; bin_cnt saturates at NUM_BINS
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      bin_cnt  <= '0;
      band_cnt <= '0;
    end else begin
      case (state)
        CLR: band_cnt <= band_end ? '0 : band_cnt + 7'd1;
        ACC: if (in_hs && (bin_cnt < 11'(NUM_BINS))) bin_cnt <= bin_cnt + 11'd1;
        OUT: if (out_hs) begin
          band_cnt <= band_end ? '0 : band_cnt + 7'd1;
          if (band_end) bin_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

  // Stage 1 capture: power of the accepted bin, valid only for in-range bins
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      s1_vld <= 1'b0;
      pow_q  <= '0;
    end else begin
      s1_vld <= in_hs && (bin_cnt < 11'(NUM_BINS));
      if (in_hs) pow_q <= bus.s_data;
    end
  end

  // Status flags: sticky framing error, per-frame saturation cleared on entering CLR
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst) begin
      frame_err <= 1'b0;
      sat       <= 1'b0;
    end else begin
      if (in_hs && bus.s_last && (bin_cnt != 11'(NUM_BINS - 1))) frame_err <= 1'b1;
      if (out_hs && band_end) sat <= 1'b0;
      else if (|sat_hit)      sat <= 1'b1;
    end
  end

  // Band array; k >= NUM_BANDS or k+1 >= NUM_BANDS simply matches no cell
  for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
    fbank_mel_cell #(.POW_W(POW_W), .ACC_W(ACC_W)) u_cell (
      .clk     (clk),
      .tb_rst  (tb_rst),
      .clr     ((state == CLR) && (band_cnt == 7'(b))),
      .sel_lo  (s1_vld && (k == 7'(b))),
      .sel_hi  (s1_vld && (k_inc == 8'(b))),
      .p_lo    (p_lo),
      .p_hi    (p_hi),
      .acc     (acc[b]),
      .sat_hit (sat_hit[b])
    );
  end

`ifdef FBANK_LOG2_EN
  logic [9:0] log_q;

  // {e[5:0], f[3:0]}: leading-one index and the four bits below it
  function automatic logic [9:0] log2_fix(input logic [ACC_W-1:0] v);
    logic [5:0] e;
    logic [3:0] f;
    e = '0;
    for (int i = 0; i < ACC_W; i++) if (v[i]) e = 6'(i);
    f = 4'(({v, 4'b0000}) >> e);
    return {e, f};
  endfunction

  // Pre-computes the encoding of the band to be shown next, so stalls see a stable value
  always_ff @(posedge clk or posedge tb_rst) begin
    if (tb_rst)                      log_q <= '0;
    else if (state == PREP)          log_q <= log2_fix(acc[0]);
    else if (out_hs && !band_end)    log_q <= log2_fix(acc[BI_W'(band_cnt + 7'd1)]);
  end

  assign bus.m_data = (state == OUT) ? ACC_W'(log_q) : '0;
`else
  assign bus.m_data = (state == OUT) ? acc[band_cnt[BI_W-1:0]] : '0;
`endif
endmodule

// File: tb/tb_fbank_mel_accum.sv
// Directed + randomized bench for fbank_mel_accum against a per-frame arithmetic model.
module tb_fbank_mel_accum;
  localparam int NUM_BINS = 257, NUM_BANDS = 40, POW_W = 32, ACC_W = 32;
  localparam longint unsigned MAXV = (64'd1 << ACC_W) - 1;
`ifdef FBANK_LOG2_EN
  localparam int EXP_LAT = 3;
`else
  localparam int EXP_LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        tb_rst = 1'b1;
  logic [9:0]  lut_addr;
  logic [16:0] lut_rd_data;
  logic        frame_err, sat;

  fbank_mel_accum_if #(.POW_W(POW_W), .ACC_W(ACC_W)) bus ();

  fbank_mel_accum #(.NUM_BINS(NUM_BINS), .NUM_BANDS(NUM_BANDS), .POW_W(POW_W), .ACC_W(ACC_W)) dut (
    .clk(clk), .tb_rst(tb_rst), .bus(bus), .lut_addr(lut_addr),
    .lut_rd_data(lut_rd_data), .frame_err(frame_err), .sat(sat)
  );

  always #5 clk = ~clk;

  logic [16:0] lut_mem [0:1023];
  always @(posedge clk) lut_rd_data <= lut_mem[lut_addr];

  int checks = 0, errors = 0;
  longint unsigned pw [0:1023];
  longint unsigned exp_band [NUM_BANDS];
  longint unsigned got_data [NUM_BANDS];
  bit exp_sat, exp_ferr;

  task automatic chk(input string tag, input longint unsigned obs, input longint unsigned exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic longint unsigned log_model(input longint unsigned v);
    int e;
    longint unsigned f;
    if (v == 0) return 0;
    e = 0;
    while ((v >> (e + 1)) != 0) e++;
    f = (e >= 4) ? ((v >> (e - 4)) % 16) : ((v << (4 - e)) % 16);
    return longint'(e) * 16 + f;
  endfunction

  function automatic longint unsigned exp_out(input int b);
`ifdef FBANK_LOG2_EN
    return log_model(exp_band[b]);
`else
    return exp_band[b];
`endif
  endfunction

  task automatic add_band(input int b, input longint unsigned v);
    longint unsigned s;
    if (b >= NUM_BANDS) return;
    s = exp_band[b] + v;
    if (s > MAXV) begin s = MAXV; exp_sat = 1; end
    exp_band[b] = s;
  endtask

  // Reference: each in-range bin splits its power by w/1024 between bands k and k+1
  task automatic model_frame(input int n);
    int k, w;
    for (int b = 0; b < NUM_BANDS; b++) exp_band[b] = 0;
    exp_sat = 0;
    for (int i = 0; i < n && i < NUM_BINS; i++) begin
      k = int'(lut_mem[i][16:10]);
      w = int'(lut_mem[i][9:0]);
      add_band(k,     (pw[i] * longint'(w)) / 1024);
      add_band(k + 1, (pw[i] * longint'(1024 - w)) / 1024);
    end
    if (n != NUM_BINS) exp_ferr = 1;
  endtask

  task automatic lut_const(input int k, input int w);
    for (int i = 0; i < 1024; i++) lut_mem[i] = {7'(k), 10'(w)};
  endtask

  task automatic lut_rand();
    for (int i = 0; i < 1024; i++) lut_mem[i] = {7'($urandom_range(0, 45)), 10'($urandom_range(0, 1023))};
  endtask

  task automatic pw_rand(input longint unsigned hi);
    for (int i = 0; i < 1024; i++) pw[i] = longint'($urandom) % (hi + 1);
  endtask

  // Drive bins with random gaps; s_last on the n-th when with_last
  task automatic send_bins(input int n, input bit with_last);
    int i, guard;
    bit v;
    i = 0; guard = 0;
    while (i < n && guard < 5000) begin
      @(negedge clk);
      guard++;
      v = ($urandom_range(0, 3) != 0);
      bus.s_valid = v;
      bus.s_data  = pw[i][POW_W-1:0];
      bus.s_last  = with_last && (i == n - 1);
      if (v && bus.s_ready) i++;
    end
    chk("bins_sent", i, n);
  endtask

  // Collect one band stream, checking latency, order, stall stability, data and flags
  task automatic collect(input bit stall);
    int got_n, cyc, lat;
    bit seen, prev_stall, rdy;
    logic [ACC_W-1:0] prev_data;
    logic [6:0] prev_band;
    got_n = 0; cyc = 0; lat = 0; seen = 0; prev_stall = 0;
    prev_data = '0; prev_band = '0;
    while (got_n < NUM_BANDS && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      bus.s_valid = 1'b0; bus.s_last = 1'b0;
      if (!seen) lat++;
      if (bus.m_valid) begin
        if (!seen) begin
          seen = 1;
          chk("latency", lat, EXP_LAT);
          chk("sat", sat, exp_sat);
          chk("frame_err", frame_err, exp_ferr);
        end
        if (prev_stall) begin
          chk("stall_data", bus.m_data, prev_data);
          chk("stall_band", bus.m_band, prev_band);
        end
        rdy = stall ? ($urandom_range(0, 2) == 0) : 1'b1;
        bus.m_ready = rdy;
        if (rdy) begin
          chk("band_idx", bus.m_band, got_n);
          chk("band_data", bus.m_data, exp_out(got_n));
          chk("m_last", bus.m_last, (got_n == NUM_BANDS - 1));
          got_data[got_n] = bus.m_data;
          got_n++;
        end
        prev_stall = !rdy; prev_data = bus.m_data; prev_band = bus.m_band;
      end else begin
        bus.m_ready = 1'($urandom_range(0, 1));
        prev_stall = 0;
      end
    end
    chk("bands_out", got_n, NUM_BANDS);
    @(negedge clk);
    bus.m_ready = 1'b0;
    chk("sat_after_clr", sat, 0);
    chk("mvalid_after", bus.m_valid, 0);
  endtask

  task automatic run_frame(input int n, input bit stall);
    model_frame(n);
    send_bins(n, 1'b1);
    collect(stall);
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_s_ready"}, bus.s_ready, 0);
    chk({tag, "_m_valid"}, bus.m_valid, 0);
    chk({tag, "_m_data"}, bus.m_data, 0);
    chk({tag, "_m_band"}, bus.m_band, 0);
    chk({tag, "_m_last"}, bus.m_last, 0);
    chk({tag, "_lut_addr"}, lut_addr, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_sat"}, sat, 0);
  endtask

  initial begin
    int cnt;
    bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b0;
    exp_ferr = 0;
    lut_const(0, 0);
    for (int i = 0; i < 1024; i++) pw[i] = 0;

    // 1: reset values, then 40 CLR cycles of s_ready low while idle
    repeat (3) @(negedge clk);
    check_reset("rst");
    tb_rst = 1'b0;
    cnt = 0;
    while (!bus.s_ready && cnt < 100) begin
      cnt++;
      @(negedge clk);
      chk("idle_m_valid", bus.m_valid, 0);
    end
    chk("clr_cycles", cnt, 40);
    chk("idle_lut_addr", lut_addr, 0);

    // 2: constant split into bands 3/4
    lut_const(3, 512);
    for (int i = 0; i < 1024; i++) pw[i] = 1024;
    run_frame(NUM_BINS, 1'b0);
`ifdef FBANK_LOG2_EN
    chk("t2_band3", got_data[3], 'h110);
    chk("t2_band4", got_data[4], 'h110);
`else
    chk("t2_band3", got_data[3], 131584);
    chk("t2_band4", got_data[4], 131584);
`endif
    chk("t2_band0", got_data[0], 0);

    // 3: out-of-range band ignored; band 40 dropped
    lut_const(127, 300);
    pw_rand(64'hFFFF_FFFF);
    run_frame(NUM_BINS, 1'b1);
    chk("t3_band20", got_data[20], 0);
    lut_const(39, 0);
    for (int i = 0; i < 1024; i++) pw[i] = 1024;
    run_frame(NUM_BINS, 1'b0);
    chk("t3_band39", got_data[39], 0);

    // 4: saturation into band 0, cleared on the following CLR
    lut_const(0, 1023);
    for (int i = 0; i < 1024; i++) pw[i] = 64'hFFFF_FFFF;
    run_frame(NUM_BINS, 1'b0);
`ifdef FBANK_LOG2_EN
    chk("t4_band0", got_data[0], 'h1FF);
`else
    chk("t4_band0", got_data[0], 64'hFFFF_FFFF);
`endif

    // random LUT / power, full frame with stalls
    lut_rand();
    pw_rand(64'h000F_FFFF);
    run_frame(NUM_BINS, 1'b1);

    // 5: short frame -> sticky frame_err; random stalls
    lut_rand();
    pw_rand(64'h00FF_FFFF);
    run_frame(101, 1'b1);
    // over-long frame: extra bins accepted but not accumulated
    lut_rand();
    pw_rand(64'h00FF_FFFF);
    run_frame(300, 1'b1);
    lut_rand();
    pw_rand(64'hFFFF_FFFF);
    run_frame(NUM_BINS, 1'b1);
    chk("t5_ferr_sticky", frame_err, 1);

    // 6: reset mid-frame at bin 50, then a clean frame
    lut_rand();
    pw_rand(64'hFFFF_FFFF);
    send_bins(50, 1'b0);
    @(negedge clk);
    bus.s_valid = 1'b0;
    tb_rst = 1'b1;
    #1;
    check_reset("midrst");
    @(negedge clk);
    tb_rst = 1'b0;
    exp_ferr = 0;
    lut_rand();
    pw_rand(64'h0FFF_FFFF);
    run_frame(NUM_BINS, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
